// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the fetch/data memory bus arbiter
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [3:0] INST_BE = 4'hF;

endpackage

// File: rtl/mem_bus_prio.sv
// rtl/mem_bus_prio.sv - data-first arbitration with a fetch starvation override
module mem_bus_prio #(
    parameter int STARVE_LIMIT = 4,
    parameter int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          inst_req_i,
    input  logic          data_req_i,
    input  logic          flush_i,
    input  logic [SW-1:0] streak_i,
    output logic          grant_inst_o,
    output logic          grant_data_o
);

    logic inst_ok;
    logic starved;

    // A redirecting flush makes the current fetch address stale, so it may not win.
    assign inst_ok      = inst_req_i && !flush_i;
    assign starved      = (streak_i == SW'(STARVE_LIMIT));
    assign grant_data_o = data_req_i && !(inst_ok && starved);
    assign grant_inst_o = inst_ok && !grant_data_o;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-outstanding arbiter sharing one SRAM port between fetch and data
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_e        state_q;
    owner_e        owner_q;
    logic          discard_q;
    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          mem_req_q;
    logic          mem_wr_q;
    logic [3:0]    mem_be_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;

    logic grant_inst;
    logic grant_data;
    logic in_idle;
    logic resp_done;

    mem_bus_prio #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .SW          (SW)
    ) u_prio (
        .inst_req_i  (inst_req),
        .data_req_i  (data_req),
        .flush_i     (flush),
        .streak_i    (streak_q),
        .grant_inst_o(grant_inst),
        .grant_data_o(grant_data)
    );

    // Handshake strobes are masked while reset is held so nothing leaks from a stale state.
    assign in_idle      = (state_q == IDLE) && !reset;
    assign resp_done    = (state_q == RESP) && mem_data_ok && !reset;

    assign inst_addr_ok = in_idle && grant_inst;
    assign data_addr_ok = in_idle && grant_data;
    assign data_data_ok = resp_done && (owner_q == OWN_DATA);
    assign inst_data_ok = resp_done && (owner_q == OWN_INST) && !discard_q && !flush;

    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign mem_req      = mem_req_q;
    assign mem_wr       = mem_wr_q;
    assign mem_be       = mem_be_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

    always_comb begin
        streak_d = streak_q;
        if (data_addr_ok && inst_req) begin
            if (streak_q != SW'(STARVE_LIMIT)) begin
                streak_d = streak_q + SW'(1);
            end
        end else if (inst_addr_ok) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_INST;
            discard_q   <= 1'b0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            streak_q <= streak_d;
            case (state_q)
                IDLE: begin
                    if (data_addr_ok) begin
                        state_q     <= REQ;
                        owner_q     <= OWN_DATA;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= data_wr;
                        mem_be_q    <= data_be;
                        mem_addr_q  <= data_addr;
                        mem_wdata_q <= data_wdata;
                    end else if (inst_addr_ok) begin
                        state_q     <= REQ;
                        owner_q     <= OWN_INST;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= 1'b0;
                        mem_be_q    <= INST_BE;
                        mem_addr_q  <= inst_addr;
                        mem_wdata_q <= 32'h0;
                    end
                end
                REQ: begin
                    if (flush && (owner_q == OWN_INST)) begin
                        discard_q <= 1'b1;
                    end
                    if (mem_addr_ok) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                    end
                end
                RESP: begin
                    if (mem_data_ok) begin
                        state_q   <= IDLE;
                        discard_q <= 1'b0;
                    end else if (flush && (owner_q == OWN_INST)) begin
                        discard_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    discard_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
